// File: rtl/toggle_pulse_pkg.sv
// Shared types and defaults for the push-button to toggle-pulse front end.
// Used by toggle_pulse_gen (optional auto-repeat: TOGGLE_PULSE_GEN_AUTO_REPEAT_EN).
package toggle_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_CYCLES_DEF   = 16;

    // Counter width for a timer that runs 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Metastability filter: first flop may go metastable, second presents a settled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Raw button -> synchronizer -> debounce FSM -> one-cycle toggle pulse plus pulse counter.
// Define TOGGLE_PULSE_GEN_AUTO_REPEAT_EN to re-pulse periodically while the button is held.
module toggle_pulse_gen
    import toggle_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              t_pulse,
    output logic              btn_level,
    output logic [PCNT_W-1:0] press_cnt
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);

    logic              btn_sync_s;
    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              pulse_q,  pulse_d;
    logic              level_q,  level_d;
    logic [PCNT_W-1:0] pcnt_q,   pcnt_d;

`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
    localparam int RPT_W = clog2_min1(REPEAT_CYCLES);
    logic [RPT_W-1:0]  rpt_q,    rpt_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (btn_in),
        .q_o   (btn_sync_s)
    );

    // Debounce next-state, timer, pulse and counter updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        pcnt_d  = pcnt_q;
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
        rpt_d   = RPT_W'(0);
`endif
        case (state_q)
            ST_IDLE: begin
                if (btn_sync_s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_sync_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_PRESSED;
                    pulse_d = 1'b1;
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_sync_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = CNT_W'(0);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
                end else if (rpt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
                    pulse_d = 1'b1;
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                end else begin
                    rpt_d   = rpt_q + RPT_W'(1);
                end
`else
                end else begin
                    state_d = ST_PRESSED;
                end
`endif
            end
            ST_DEB_RELEASE: begin
                if (btn_sync_s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
        level_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
    end

    // State and all outputs registered together so they change on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            pcnt_q  <= PCNT_W'(0);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
            rpt_q   <= RPT_W'(0);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            pcnt_q  <= pcnt_d;
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign t_pulse   = pulse_q;
    assign btn_level = level_q;
    assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench for toggle_pulse_gen: expected pulses are queued by stimulus, popped by a monitor.
module tb_toggle_pulse_gen;

    localparam int PW = 2;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_in = 1'b0;
    logic          t_pulse;
    logic          btn_level;
    logic [PW-1:0] press_cnt;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    logic prev_pulse = 1'b0;

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (16),
        .PCNT_W          (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pulse(input int at_cyc);
        exp_t e;
        exp_cnt = (exp_cnt + 1) % (1 << PW);
        e.cyc = at_cyc;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_cnt = 0;
        wait_cycles(3);
        check("reset_t_pulse", int'(t_pulse), 0);
        check("reset_level", int'(btn_level), 0);
        check("reset_press_cnt", int'(press_cnt), 0);
        rst = 1'b1;
        wait_cycles(2);
    endtask

    // Clean press held `hold` cycles past the pulse, then a full release.
    task automatic do_press(input int hold);
        int c;
        int d;
        c = cyc;
        btn_in = 1'b1;
        push_pulse(c + 7);
        wait_cycles(6);
        check("press_level_before", int'(btn_level), 0);
        wait_cycles(1);
        check("press_level_after", int'(btn_level), 1);
        wait_cycles(hold);
        d = cyc;
        btn_in = 1'b0;
        wait_cycles(6);
        check("release_level_before", int'(btn_level), 1);
        wait_cycles(1);
        check("release_level_after", int'(btn_level), 0);
        wait_cycles(3);
    endtask

    // Monitor: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            if (t_pulse) begin
                if (prev_pulse) begin
                    checks++;
                    failures++;
                    $display("FAIL back_to_back: t_pulse high on consecutive cycles at %0d", cyc);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_press_cnt", int'(press_cnt), e.cnt);
                    check("pulse_level", int'(btn_level), 1);
                end
            end
        end
        prev_pulse = t_pulse;
    end

    initial begin
        int c;
        int r;

        // Reset state
        wait_cycles(2);
        do_reset();

        // Clean press
        do_press(8);

        // Bounce on press: 3 high, 2 low, then held high
        btn_in = 1'b1;
        wait_cycles(3);
        btn_in = 1'b0;
        wait_cycles(2);
        c = cyc;
        btn_in = 1'b1;
        push_pulse(c + 7);
        wait_cycles(9);

        // Release bounce while pressed: level must hold
        btn_in = 1'b0;
        wait_cycles(2);
        btn_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("release_bounce_level", int'(btn_level), 1);
            wait_cycles(1);
        end
        btn_in = 1'b0;
        wait_cycles(8);
        check("full_release_level", int'(btn_level), 0);

        // Wrap of the 2-bit counter: 1,2,3,0,1
        do_reset();
        for (int i = 0; i < 5; i++) do_press(4);
        check("wrap_final_cnt", int'(press_cnt), 1);

        // Reset mid-debounce
        btn_in = 1'b1;
        wait_cycles(4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("midreset_t_pulse", int'(t_pulse), 0);
        check("midreset_level", int'(btn_level), 0);
        check("midreset_press_cnt", int'(press_cnt), 0);
        wait_cycles(3);
        r = cyc;
        rst = 1'b1;
        push_pulse(r + 7);
        wait_cycles(6);
        check("post_reset_level_before", int'(btn_level), 0);
        wait_cycles(3);
        btn_in = 1'b0;
        wait_cycles(10);

        // Long hold: auto-repeat if enabled
        do_reset();
        c = cyc;
        btn_in = 1'b1;
        push_pulse(c + 7);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
        push_pulse(c + 23);
        push_pulse(c + 39);
`endif
        wait_cycles(47);
        btn_in = 1'b0;
        wait_cycles(10);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
        check("hold_press_cnt", int'(press_cnt), 3);
`else
        check("hold_press_cnt", int'(press_cnt), 1);
`endif

        wait_cycles(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: %0d expected pulses never seen", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
